// File: rtl/floo_route_lock_if.sv
// Flit interface of floo_route_lock.
// Carries the input flit (valid_i/ready_o, destination, route, tail flag,
// payload) and the registered output flit (valid_o/ready_i, selected output
// index and its one-hot form, forwarded route, tail flag, payload, error pulse).
// slave  : router side (consumes the input flit, produces the output flit).
// master : environment side (drives the input flit, sinks the output flit).
interface floo_route_lock_if #(
    parameter int XYW    = 4,
    parameter int RouteW = 16,
    parameter int DataW  = 64,
    parameter int NumOut = 5
);
    localparam int IdxW = $clog2(NumOut);

    // input flit
    logic              valid_i;
    logic              ready_o;
    logic [XYW-1:0]    dst_x_i;
    logic [XYW-1:0]    dst_y_i;
    logic [1:0]        dst_port_i;
    logic [RouteW-1:0] route_i;
    logic              last_i;
    logic [DataW-1:0]  data_i;

    // output flit
    logic              valid_o;
    logic              ready_i;
    logic [IdxW-1:0]   out_idx_o;
    logic [NumOut-1:0] out_sel_o;
    logic [RouteW-1:0] route_o;
    logic              last_o;
    logic [DataW-1:0]  data_o;
    logic              err_o;

    modport slave (
        input  valid_i, dst_x_i, dst_y_i, dst_port_i, route_i, last_i, data_i, ready_i,
        output ready_o, valid_o, out_idx_o, out_sel_o, route_o, last_o, data_o, err_o
    );

    modport master (
        output valid_i, dst_x_i, dst_y_i, dst_port_i, route_i, last_i, data_i, ready_i,
        input  ready_o, valid_o, out_idx_o, out_sel_o, route_o, last_o, data_o, err_o
    );
endinterface

// File: rtl/floo_route_lock.sv
// Router output-port selection with wormhole packet locking.
// The head flit of a packet picks an output (XY dimension-order routing with
// optional ruche express links, or source routing); body and tail flits reuse
// the locked choice. A single output register gives one cycle of latency and
// full throughput.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   own_x_i, own_y_i   : this router's coordinates (quasi-static)
//   flit (slave)       : input flit handshake and registered output flit
// Output indices: N=0 E=1 S=2 W=3, local k=4+k, RucheN/E/S/W=4+NumLocal+0..3.
module floo_route_lock #(
    parameter string RouteAlgo   = "XYRouting",
    parameter int    NumLocal    = 1,
    parameter int    EnRuche     = 0,
    parameter int    RucheFactor = 2,
    parameter int    XYW         = 4,
    parameter int    RouteW      = 16,
    parameter int    DataW       = 64,
    localparam int   NumOut      = 4 + NumLocal + 4 * EnRuche,
    localparam int   IdxW        = $clog2(NumOut),
    localparam int   HopW        = IdxW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [XYW-1:0]   own_x_i,
    input  logic [XYW-1:0]   own_y_i,
    floo_route_lock_if.slave flit
);
    if (RouteAlgo != "XYRouting" && RouteAlgo != "SourceRouting") begin : gBadAlgo
        $error("floo_route_lock: illegal RouteAlgo");
    end
    if (NumLocal < 1 || NumLocal > 4) begin : gBadLocal
        $error("floo_route_lock: NumLocal must be 1..4");
    end

    typedef enum logic {Idle, Locked} stateE;

    stateE             state, stateNext;
    logic [IdxW-1:0]   routeQ, routeNext;

    logic [IdxW-1:0]   headIdx;
    logic              headErr;
    logic [RouteW-1:0] headRoute;

    logic              readyO, accept, isHead;
    logic [IdxW-1:0]   curIdx;
    logic [RouteW-1:0] curRoute;

    logic              validQ, errQ, lastQ;
    logic [IdxW-1:0]   idxQ;
    logic [NumOut-1:0] selQ;
    logic [RouteW-1:0] routeOutQ;
    logic [DataW-1:0]  dataQ;

    assign readyO = !validQ || flit.ready_i;
    assign accept = flit.valid_i && readyO;

    // Head-flit route computation
    if (RouteAlgo == "XYRouting") begin : gXy
        localparam int RucheBase = 4 + NumLocal;
        logic signed [XYW:0] dx;
        int                  dxI;

        always_comb begin
            dx        = $signed({1'b0, flit.dst_x_i}) - $signed({1'b0, own_x_i});
            dxI       = int'(dx);
            headErr   = 1'b0;
            headRoute = flit.route_i;
            if (dxI > 0) begin
                headIdx = (EnRuche != 0 && dxI >= RucheFactor) ? IdxW'(RucheBase + 1) : IdxW'(1);
            end else if (dxI < 0) begin
                headIdx = (EnRuche != 0 && -dxI >= RucheFactor) ? IdxW'(RucheBase + 3) : IdxW'(3);
            end else if (flit.dst_y_i > own_y_i) begin
                headIdx = IdxW'(0);
            end else if (flit.dst_y_i < own_y_i) begin
                headIdx = IdxW'(2);
            end else if (int'(flit.dst_port_i) >= NumLocal) begin
                // nonexistent local port: fall back to local 0 and flag it
                headIdx = IdxW'(4);
                headErr = 1'b1;
            end else begin
                headIdx = IdxW'(4 + int'(flit.dst_port_i));
            end
        end
    end else begin : gSrc
        logic [HopW-1:0] take;
        logic            unusedSrc;

        // coordinates play no part in source routing
        assign unusedSrc = ^{own_x_i, own_y_i, flit.dst_x_i, flit.dst_y_i, flit.dst_port_i};

        always_comb begin
            take      = flit.route_i[HopW-1:0];
            headRoute = flit.route_i >> HopW;   // consume this hop
            headIdx   = take;
            headErr   = 1'b0;
            if (int'(take) >= NumOut) begin
                headIdx = IdxW'(4);
                headErr = 1'b1;
            end
        end
    end

    // Packet lock FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= Idle;
            routeQ <= '0;
        end else begin
            state  <= stateNext;
            routeQ <= routeNext;
        end
    end

    always_comb begin
        stateNext = state;
        routeNext = routeQ;
        isHead    = (state == Idle);
        curIdx    = isHead ? headIdx : routeQ;
        curRoute  = isHead ? headRoute : flit.route_i;
        if (accept) begin
            if (isHead) begin
                routeNext = headIdx;
                stateNext = flit.last_i ? Idle : Locked;
            end else if (flit.last_i) begin
                stateNext = Idle;
            end
        end
    end

    // Output register. err_o is a single-cycle pulse even if the flit then
    // stalls; every other output holds until the flit is taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            validQ    <= 1'b0;
            errQ      <= 1'b0;
            idxQ      <= '0;
            selQ      <= '0;
            routeOutQ <= '0;
            lastQ     <= 1'b0;
            dataQ     <= '0;
        end else begin
            errQ <= 1'b0;
            if (accept) begin
                validQ    <= 1'b1;
                errQ      <= isHead && headErr;
                idxQ      <= curIdx;
                selQ      <= NumOut'(1) << curIdx;
                routeOutQ <= curRoute;
                lastQ     <= flit.last_i;
                dataQ     <= flit.data_i;
            end else if (flit.ready_i) begin
                validQ <= 1'b0;
            end
        end
    end

    assign flit.ready_o   = readyO;
    assign flit.valid_o   = validQ;
    assign flit.err_o     = errQ;
    assign flit.out_idx_o = idxQ;
    assign flit.out_sel_o = selQ;
    assign flit.route_o   = routeOutQ;
    assign flit.last_o    = lastQ;
    assign flit.data_o    = dataQ;
endmodule

// File: doc/floo_route_lock.md
FLOO_ROUTE_LOCK -- requirements
Module: floo_route_lock

Interface
REQ-001 SHALL have parameter RouteAlgo, default XYRouting; selects the routing mode, legal values XYRouting and SourceRouting; any other value is an elaboration error.
REQ-002 SHALL have parameter NumLocal, default 1; number of local eject ports, range 1..4.
REQ-003 SHALL have parameter EnRuche, default 0; 1 adds the four ruche outputs.
REQ-004 SHALL have parameter RucheFactor, default 2; minimum x-distance, in hops, for using a ruche output.
REQ-005 SHALL have parameter XYW, default 4; width of each coordinate.
REQ-006 SHALL have parameter RouteW, default 16; width of the source-route field.
REQ-007 SHALL have parameter DataW, default 64; payload width.
REQ-008 SHALL have derived parameters: NumOut = 4 + NumLocal + 4*EnRuche, IdxW = clog2(NumOut), and HopW = IdxW (route bits consumed per hop).
REQ-009 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-010 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-011 SHALL have port own_x_i / own_y_i, input, XYW each: this router's coordinates, quasi-static.
REQ-012 SHALL have port valid_i / ready_o, input/output, 1 each: input flit handshake.
REQ-013 SHALL have port dst_x_i / dst_y_i, input, XYW each: destination coordinates, sampled on head flits.
REQ-014 SHALL have port dst_port_i, input, 2 bits: destination local port index.
REQ-015 SHALL have port route_i, input, RouteW: source-route field.
REQ-016 SHALL have port last_i, input, 1 bit: tail flag of the flit.
REQ-017 SHALL have port data_i, input, DataW: payload.
REQ-018 SHALL have port valid_o / ready_i, output/input, 1 each: output flit handshake.
REQ-019 SHALL have port out_idx_o, output, IdxW: selected output index.
REQ-020 SHALL have port out_sel_o, output, NumOut: one-hot form of out_idx_o.
REQ-021 SHALL have ports route_o (RouteW), last_o (1) and data_o (DataW), outputs: the forwarded flit.
REQ-022 SHALL have port err_o, output, 1 bit: one-cycle pulse on an illegal route.

Function
REQ-023 SHALL number output indices as: N=0, E=1, S=2, W=3; local port k = 4+k; RucheN/E/S/W = 4+NumLocal+0..3.
REQ-024 SHALL contain a one-entry output register with 1-cycle latency, ready_o = !valid_o || ready_i, and full throughput under continuous ready_i.
REQ-025 SHALL implement an FSM with states IDLE and LOCKED; a flit accepted in IDLE is a head flit.
REQ-026 SHALL compute the route for a head flit, store it in route_q, and move to LOCKED if last_i=0; a head flit with last_i=1 stays IDLE.
REQ-027 SHALL, in LOCKED, give each accepted flit route_q unchanged, and return to IDLE on acceptance of a flit with last_i=1.
REQ-028 SHALL, in XYRouting mode, compare x first, then y:
- dx = dst_x_i - own_x_i, treated as signed with XYW+1 bits.
- dx > 0: East; RucheEast if EnRuche && dx >= RucheFactor.
- dx < 0: West; RucheWest if EnRuche && -dx >= RucheFactor.
- dx = 0: North if dst_y_i > own_y_i, South if dst_y_i < own_y_i.
- dst = own: local port dst_port_i.
REQ-029 SHALL, in XYRouting mode, pulse err_o and select local port 0 when dst_port_i >= NumLocal.
REQ-030 SHALL, in SourceRouting mode:
- take the index from route_i[HopW-1:0];
- on head flits, forward route_o = route_i >> HopW, zero-filled;
- on body flits, forward route_o = route_i unchanged.
REQ-031 SHALL, in SourceRouting mode, pulse err_o and substitute index 4 when the taken index is >= NumOut.
REQ-032 SHALL assert err_o in the same cycle valid_o first presents the offending head flit, for exactly one cycle.
REQ-033 SHALL hold all outputs stable while valid_o=1 and ready_i=0.
REQ-034 SHALL ignore valid_i while ready_o=0; no flit is lost or duplicated.

Reset
REQ-035 SHALL, on rst_i=1 at a clock edge, clear valid_o, err_o, out_idx_o, out_sel_o, route_o, last_o and data_o to 0 and set the FSM to IDLE.
REQ-036 SHALL abandon any in-flight packet lock on reset; the first flit accepted after reset is a head flit.
REQ-037 SHALL drive ready_o=1 in the first cycle after reset deasserts.

Verification
REQ-038 SHALL cover: XY with own=(1,1), dst=(3,1), EnRuche=1, RucheFactor=2 -> out_idx=4+NumLocal+1 (RucheEast), valid_o one cycle after acceptance.
REQ-039 SHALL cover: XY with own=(2,2), 3-flit packet dst=(2,0), where the body flits carry dst=(0,0) -> all three flits out_idx=2 (South), FSM back in IDLE after the tail.
REQ-040 SHALL cover: SourceRouting with NumLocal=1 (IdxW=3), head route_i=16'h00D1 -> out_idx=1, route_o=16'h001A; the following body flit leaves route_i unchanged.
REQ-041 SHALL cover: SourceRouting with head index 7 and NumOut=5 -> err_o pulses once, out_idx=4.
REQ-042 SHALL cover: ready_i held low for 5 cycles with valid_i high -> outputs stable, ready_o=0, no flit lost; 4 flits in 4 cycles once ready_i returns.
REQ-043 SHALL cover: rst_i asserted mid-packet -> valid_o=0 next cycle; the next flit is routed as a head flit from its own fields.
